// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Holds the FSM state encoding and the slice width.
// No logic; imported by the slice cell and the sequencer top.
package nibble_serial_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_4bit.sv
// Purpose: one 4-bit ripple adder slice, time-shared by the sequencer.
// Latency: combinational.
// Backpressure: none (pure datapath cell).
module adder_4bit
  import nibble_serial_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, cin_i};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: WIDTH-bit add done one nibble per clock through a single 4-bit slice, LSB first.
// Latency: out_valid rises NIB edges after the accepting edge; initiation interval NIB+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Optional: define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output out_ovf.
module nibble_serial_adder_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NIB    = WIDTH / NIB_W;
  localparam int IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BASE_W = IDX_W + $clog2(NIB_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  // Reject widths that cannot be split into whole nibbles.
  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [BASE_W-1:0] base;
  logic [NIB_W-1:0]  a_nib, b_nib, slice_sum;
  logic              slice_cout;

  // Bit offset of the current nibble (idx * 4).
  assign base  = {idx_q, 2'b00};
  assign a_nib = a_q[base +: NIB_W];
  assign b_nib = b_q[base +: NIB_W];

  adder_4bit u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;
  // Carry into the slice's top bit recovered from its 1-bit sum: s3 = a3 ^ b3 ^ c3.
  assign msb_cin = a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ slice_sum[NIB_W-1];
  assign out_ovf = ovf_q;
`endif

  // Next-state: accept in IDLE, one nibble per cycle in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[base +: NIB_W] = slice_sum;
        carry_d              = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = msb_cin ^ slice_cout;
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed literal cases plus random traffic
// against a transaction-level model (one add in flight, result due NIB edges after accept).
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             out_ovf;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH:0] res;
    logic           ovf;
    int             acc;
  } txn_t;

  txn_t q[$];
  int   cyc = 0;
  bit   acc_pulse = 0;

  function automatic txn_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input int acc);
    txn_t t;
    int   sa, sb, s;
    t.res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb + int'(cin);
    t.ovf = (s > 32767) || (s < -32768);
    t.acc = acc;
    return t;
  endfunction

  function automatic bit model_ov();
    return (q.size() != 0) && (cyc >= q[0].acc + NIB);
  endfunction

  // Advance the model at each rising edge using the inputs seen just before it.
  always @(posedge clk) begin
    bit idle, ov;
    if (!rst_n) begin
      q.delete();
      acc_pulse = 0;
    end else begin
      idle = (q.size() == 0);
      ov   = model_ov();
      acc_pulse = 0;
      if (ov && out_ready) void'(q.pop_front());
      if (idle && in_valid) begin
        q.push_back(ref_add(in_a, in_b, in_cin, cyc + 1));
        acc_pulse = 1;
      end
    end
    cyc++;
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    bit idle, ov;
    if (rst_n) begin
      idle = (q.size() == 0);
      ov   = model_ov();
      chk("in_ready", in_ready, idle);
      chk("busy", busy, !idle);
      chk("out_valid", out_valid, ov);
      if (ov) begin
        chk("out_sum", out_sum, q[0].res[WIDTH-1:0]);
        chk("out_cout", out_cout, q[0].res[WIDTH]);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("out_ovf", out_ovf, q[0].ovf);
`endif
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_accept(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc_pulse && n < 50);
    if (!acc_pulse) chk({nm, " accept timeout"}, 0, 1);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input logic [WIDTH-1:0] es, input logic ec, input logic eovf,
                       input string nm);
    int n;
    @(negedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(nm);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " latency"}, n, NIB);
    chk({nm, " sum"}, out_sum, es);
    chk({nm, " cout"}, out_cout, ec);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk({nm, " ovf"}, out_ovf, eovf);
`else
    if (eovf === 1'bx) chk({nm, " ovf arg"}, 0, 1);
`endif
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc_cyc[3];
    logic [WIDTH-1:0] held;
    bit stable;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_cout", out_cout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", in_ready, 1);

    // Literal cases pinning the model.
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ffff+1");
    do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "1234+4321+1");
    do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "0+0+1");
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "ffff+ffff+1");
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "7fff+1");
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "8000+8000");
`endif

    // Backpressure: result held, new in_valid ignored, in_ready one cycle after handshake.
    @(negedge clk); #1;
    in_a = 16'h00FF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept("bp");
    in_a = 16'h1111; in_b = 16'h2222;
    repeat (NIB) @(posedge clk);
    #1;
    chk("bp valid", out_valid, 1);
    chk("bp sum", out_sum, 16'h0100);
    held = out_sum;
    stable = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_sum !== held || !out_valid || in_ready) stable = 0;
    end
    chk("bp stable", stable, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp in_ready after handshake", in_ready, 1);
    chk("bp out_valid after handshake", out_valid, 0);

    // Reset in the middle of a run.
    @(negedge clk); #1;
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0; in_valid = 1'b1;
    wait_accept("rst");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst partial sum", out_sum, 16'h00FF);
    rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst out_sum", out_sum, 0);
    chk("rst out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "3+4 after reset");

    // Back-to-back with in_valid held high.
    @(negedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1000 * i + 16'h0F0F; in_b = 16'h00F1 + i; in_cin = i[0];
      in_valid = 1'b1;
      wait_accept("b2b");
      acc_cyc[i] = cyc;
    end
    in_valid = 1'b0;
    chk("b2b interval 1", acc_cyc[1] - acc_cyc[0], NIB + 2);
    chk("b2b interval 2", acc_cyc[2] - acc_cyc[1], NIB + 2);
    drain();

    // Random traffic; producer holds data until accepted.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (!in_valid || acc_pulse) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_a   = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
        in_b   = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
        in_cin = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
